// File: rtl/stack_op_ctrl.sv
// stack_op_ctrl: multicycle sequencer for PUSH/POP/JAL register-bank and stack-memory accesses
module stack_op_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] regdst_sel,
  output logic       reg_write,
  output logic [1:0] sp_alu_op,
  output logic       mem_addr_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] wb_src_sel
);
  typedef enum logic [3:0] {
    IDLE, PUSH_SP, PUSH_MEM, POP_RD, POP_WAIT, POP_WB, POP_SP, JAL_WB, DONE
  } state_t;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:     if (start && op != 2'd3)
                  state_d = op == 2'd0 ? PUSH_SP : op == 2'd1 ? POP_RD : JAL_WB;
      PUSH_SP:  state_d = PUSH_MEM;
      PUSH_MEM: state_d = DONE;
      POP_RD: begin
        cnt_d   = LAT_M1;
        state_d = MEM_LAT == 1 ? POP_WB : POP_WAIT;
      end
      POP_WAIT: begin
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        state_d = cnt_q <= 4'd1 ? POP_WB : POP_WAIT;
      end
      POP_WB:   state_d = POP_SP;
      POP_SP:   state_d = DONE;
      JAL_WB:   state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      regdst_sel   <= '0;
      reg_write    <= 1'b0;
      sp_alu_op    <= '0;
      mem_addr_sel <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      wb_src_sel   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy         <= state_d != IDLE;
      done         <= state_d == DONE;
      error        <= state_q == IDLE && start && op == 2'd3;
      regdst_sel   <= (state_d == PUSH_SP || state_d == POP_SP) ? 3'd2 :
                      state_d == JAL_WB ? 3'd3 : 3'd0;
      reg_write    <= state_d inside {PUSH_SP, POP_WB, POP_SP, JAL_WB};
      sp_alu_op    <= state_d == PUSH_SP ? 2'b01 : state_d == POP_SP ? 2'b10 : 2'b00;
      mem_addr_sel <= state_d inside {PUSH_MEM, POP_RD, POP_WAIT};
      mem_read     <= state_d == POP_RD;
      mem_write    <= state_d == PUSH_MEM;
      wb_src_sel   <= state_d == POP_WB ? 2'd1 : state_d == JAL_WB ? 2'd2 : 2'd0;
    end
  end
endmodule

// File: tb/tb_stack_op_ctrl.sv
// tb_stack_op_ctrl: directed checks of stack_op_ctrl sequences with MEM_LAT=2 and MEM_LAT=1
module tb_stack_op_ctrl;
  logic       clk = 0, reset = 0, start = 0;
  logic [1:0] op = 0;
  logic       busy, done, error, reg_write, mem_addr_sel, mem_read, mem_write;
  logic [2:0] regdst_sel;
  logic [1:0] sp_alu_op, wb_src_sel;
  logic       busy1, done1, error1, reg_write1, mem_addr_sel1, mem_read1, mem_write1;
  logic [2:0] regdst_sel1;
  logic [1:0] sp_alu_op1, wb_src_sel1;
  int checks = 0, errors = 0;
  // {busy,done,error,regdst,reg_write,sp_op,addr_sel,rd,wr,wb}
  localparam logic [13:0] S_IDLE = 14'b0_0_0_000_0_00_0_0_0_00;
  localparam logic [13:0] S_PSP  = 14'b1_0_0_010_1_01_0_0_0_00;
  localparam logic [13:0] S_PMEM = 14'b1_0_0_000_0_00_1_0_1_00;
  localparam logic [13:0] S_PRD  = 14'b1_0_0_000_0_00_1_1_0_00;
  localparam logic [13:0] S_PWT  = 14'b1_0_0_000_0_00_1_0_0_00;
  localparam logic [13:0] S_PWB  = 14'b1_0_0_000_1_00_0_0_0_01;
  localparam logic [13:0] S_PSP2 = 14'b1_0_0_010_1_10_0_0_0_00;
  localparam logic [13:0] S_JAL  = 14'b1_0_0_011_1_00_0_0_0_10;
  localparam logic [13:0] S_DONE = 14'b1_1_0_000_0_00_0_0_0_00;
  localparam logic [13:0] S_ERR  = 14'b0_0_1_000_0_00_0_0_0_00;
  wire [13:0] obs  = {busy, done, error, regdst_sel, reg_write, sp_alu_op,
                      mem_addr_sel, mem_read, mem_write, wb_src_sel};
  wire [13:0] obs1 = {busy1, done1, error1, regdst_sel1, reg_write1, sp_alu_op1,
                      mem_addr_sel1, mem_read1, mem_write1, wb_src_sel1};
  stack_op_ctrl #(.MEM_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .busy(busy), .done(done),
    .error(error), .regdst_sel(regdst_sel), .reg_write(reg_write), .sp_alu_op(sp_alu_op),
    .mem_addr_sel(mem_addr_sel), .mem_read(mem_read), .mem_write(mem_write),
    .wb_src_sel(wb_src_sel));
  stack_op_ctrl #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .busy(busy1), .done(done1),
    .error(error1), .regdst_sel(regdst_sel1), .reg_write(reg_write1), .sp_alu_op(sp_alu_op1),
    .mem_addr_sel(mem_addr_sel1), .mem_read(mem_read1), .mem_write(mem_write1),
    .wb_src_sel(wb_src_sel1));
  always #5 clk = ~clk;
  task automatic test_reset();
    reset = 1; start = 1; op = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== S_IDLE) begin errors++; $display("FAIL reset_hold got %b exp %b", obs, S_IDLE); end
    checks++;
    if (obs1 !== S_IDLE) begin errors++; $display("FAIL reset_hold1 got %b exp %b", obs1, S_IDLE); end
    reset = 0; start = 0;
    @(posedge clk); #1;
    checks++;
    if (obs !== S_IDLE) begin errors++; $display("FAIL reset_release got %b exp %b", obs, S_IDLE); end
  endtask
  task automatic test_push();
    logic [13:0] exp [4] = '{S_PSP, S_PMEM, S_DONE, S_IDLE};
    start = 1; op = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      start = 0;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL push cyc%0d got %b exp %b", i + 1, obs, exp[i]); end
    end
  endtask
  task automatic test_pop2();
    logic [13:0] exp [6] = '{S_PRD, S_PWT, S_PWB, S_PSP2, S_DONE, S_IDLE};
    start = 1; op = 2'd1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      start = 0;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL pop2 cyc%0d got %b exp %b", i + 1, obs, exp[i]); end
    end
  endtask
  task automatic test_pop1();
    logic [13:0] exp [5] = '{S_PRD, S_PWB, S_PSP2, S_DONE, S_IDLE};
    start = 1; op = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 0;
      checks++;
      if (obs1 !== exp[i]) begin errors++; $display("FAIL pop1 cyc%0d got %b exp %b", i + 1, obs1, exp[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_back_to_back();
    logic [13:0] exp [6] = '{S_JAL, S_DONE, S_IDLE, S_JAL, S_DONE, S_IDLE};
    start = 1; op = 2'd2;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 3) start = 0;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL jal_b2b cyc%0d got %b exp %b", i + 1, obs, exp[i]); end
    end
  endtask
  task automatic test_illegal();
    logic [13:0] exp [3] = '{S_ERR, S_IDLE, S_IDLE};
    start = 1; op = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = 0;
      checks++;
      if (obs !== exp[i]) begin errors++; $display("FAIL illegal cyc%0d got %b exp %b", i + 1, obs, exp[i]); end
    end
  endtask
  task automatic test_reset_mid_pop();
    start = 1; op = 2'd1;
    @(posedge clk); #1;
    start = 0;
    checks++;
    if (obs !== S_PRD) begin errors++; $display("FAIL midpop_rd got %b exp %b", obs, S_PRD); end
    @(posedge clk); #1;
    checks++;
    if (obs !== S_PWT) begin errors++; $display("FAIL midpop_wait got %b exp %b", obs, S_PWT); end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    checks++;
    if (obs !== S_IDLE) begin errors++; $display("FAIL midpop_reset got %b exp %b", obs, S_IDLE); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== S_IDLE) begin errors++; $display("FAIL midpop_after cyc%0d got %b exp %b", i, obs, S_IDLE); end
    end
  endtask
  initial begin
    test_reset();
    test_push();
    test_pop2();
    test_pop1();
    test_back_to_back();
    test_illegal();
    test_reset_mid_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_op_ctrl.md
# stack_op_ctrl

Multicycle sequencer for the register-bank write port and stack memory accesses of PUSH, POP and JAL. It drives the 3-bit register-destination selector, RegWrite, the SP adjust operation, the memory address source and read/write strobes, and the write-back source. It sits beside the main control FSM, which hands off one of these operations with `start` and resumes when `done` pulses.

## Interface
Parameters:
- `MEM_LAT`, default 2: memory read latency in cycles, legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: operation request, sampled in IDLE only.
- `op` input 2: operation code. 0 = PUSH, 1 = POP, 2 = JAL, 3 = illegal.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle completion pulse.
- `error` output 1: one-cycle pulse when `op`=3 is requested.
- `regdst_sel` output 3: register destination select. 0 = rt, 1 = rd, 2 = $29, 3 = $31, 4 = rs. This block only emits 0, 2 or 3.
- `reg_write` output 1: register bank write enable.
- `sp_alu_op` output 2: SP adjust. 00 = none, 01 = SP-4, 10 = SP+4.
- `mem_addr_sel` output 1: memory address source. 0 = ALU/PC path, 1 = SP.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe.
- `wb_src_sel` output 2: write-back data source. 0 = ALU result, 1 = memory data, 2 = PC.

## Operation
- Moore FSM. All outputs decode from the registered state and are glitch-free. An output that is not listed for a state is 0.
- IDLE: `busy`=0. If `start`=1 and `op`≠3, latch `op` and go to the first state of that sequence. If `start`=1 and `op`=3, pulse `error` next cycle and stay in IDLE.
- PUSH sequence:
  - PUSH_SP: `regdst_sel`=2, `sp_alu_op`=01, `wb_src_sel`=0, `reg_write`=1.
  - PUSH_MEM: `mem_addr_sel`=1, `mem_write`=1. This stores rt at the new SP.
  - Then DONE.
- POP sequence:
  - POP_RD: `mem_addr_sel`=1, `mem_read`=1. Load the wait counter with MEM_LAT-1.
  - POP_WAIT: `mem_addr_sel`=1. Decrement the counter each cycle and leave when it reaches 0. This state is skipped entirely when MEM_LAT=1.
  - POP_WB: `regdst_sel`=0, `wb_src_sel`=1, `reg_write`=1.
  - POP_SP: `regdst_sel`=2, `sp_alu_op`=10, `wb_src_sel`=0, `reg_write`=1.
  - Then DONE.
- JAL sequence:
  - JAL_WB: `regdst_sel`=3, `wb_src_sel`=2, `reg_write`=1.
  - Then DONE.
- DONE: `done`=1 and `busy`=1 for one cycle, then return to IDLE.
- `busy`=1 in every non-IDLE state. `start` and `op` are ignored while `busy`=1, and a new `start` is accepted in the cycle after DONE.
- At most one of `reg_write`, `mem_write`, `mem_read` is high in any cycle.
- `regdst_sel` is 0 in IDLE and DONE.
- Wait counter: 4 bits. It never underflows, and it reloads only in POP_RD.

## Timing
- Cycle 0 is the edge on which `start` is sampled. The first sequence state is visible from cycle 1.
- Latency from the `start` edge to `done` high:
  - PUSH: 3 cycles.
  - POP: MEM_LAT+3 cycles.
  - JAL: 2 cycles.
  - Illegal op: `error` is high in cycle 1 and `busy` stays 0.
- Memory read data is valid in POP_WB, which is MEM_LAT cycles after `mem_read` rises.
- Reset values: state IDLE, counter 0, latched op 0. All outputs are 0, including `regdst_sel`=0 and `sp_alu_op`=00.
- Reset asserted mid-sequence: the next cycle is IDLE with all strobes 0. No further register or memory write occurs, and `done` is not pulsed.
- `reset` and `start` high together: reset wins and the request is dropped.

## Test plan
- Reset then PUSH:
  - Stimulus: assert `reset`, release it, then `start`=1, `op`=0.
  - Required response, cycles 1..3:
    - Cycle 1: `reg_write`=1, `regdst_sel`=2, `sp_alu_op`=01.
    - Cycle 2: `mem_write`=1, `mem_addr_sel`=1.
    - Cycle 3: `done`=1.
    - Cycle 4: `busy`=0.
- POP with MEM_LAT=2:
  - Stimulus: `start`=1, `op`=1.
  - Required response:
    - Cycle 1: `mem_read`=1.
    - Cycle 2: wait, `mem_addr_sel`=1.
    - Cycle 3: `reg_write`=1, `regdst_sel`=0, `wb_src_sel`=1.
    - Cycle 4: `reg_write`=1, `regdst_sel`=2, `sp_alu_op`=10.
    - Cycle 5: `done`=1.
- POP with MEM_LAT=1:
  - Stimulus: same as above.
  - Required response: no wait cycle; `done` is high in cycle 4.
- JAL followed by back-to-back start:
  - Stimulus: `op`=2, with `start` held high throughout.
  - Required response:
    - Cycle 1: `regdst_sel`=3, `wb_src_sel`=2, `reg_write`=1.
    - Cycle 2: `done`=1.
    - Cycle 3: the next operation is accepted, so its first state is visible in cycle 4.
- Illegal op:
  - Stimulus: `op`=3 with `start`=1.
  - Required response: `error`=1 for exactly cycle 1. `busy`, `reg_write` and `mem_write` stay 0.
- Reset mid-POP:
  - Stimulus: assert `reset` while in POP_WAIT.
  - Required response: the following cycle is IDLE with all outputs 0. No `reg_write` occurs afterward, and `done` never pulses.
